// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared definitions for the MEM-stage data-memory responder.
//   - DATA_W / ADDR_W : store-data and byte-address widths
//   - MEM_W_*         : RV32 funct3 load/store width codes
//   - mau_state_t     : responder FSM states (2-bit encoding)
//   - is_misaligned() : natural-alignment test used when MISALIGN_CHECK_EN is defined
package mem_access_unit_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [2:0] MEM_W_B  = 3'b000;
    localparam logic [2:0] MEM_W_H  = 3'b001;
    localparam logic [2:0] MEM_W_W  = 3'b010;
    localparam logic [2:0] MEM_W_BU = 3'b100;
    localparam logic [2:0] MEM_W_HU = 3'b101;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_REQ  = 2'd1,
        MAU_RESP = 2'd2
    } mau_state_t;

    // Unlisted width codes behave as word accesses, so they need word alignment.
    function automatic logic is_misaligned(input logic [2:0] width, input logic [1:0] addr_lo);
        logic mis;
        case (width)
            MEM_W_B, MEM_W_BU: mis = 1'b0;
            MEM_W_H, MEM_W_HU: mis = addr_lo[0];
            default:           mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// mem_lane_align
//   Combinational byte-lane formatter for a 32-bit data bus.
//   Ports:
//     width       in  3   funct3 width code
//     addr_lo     in  2   byte offset within the word
//     we          in  1   store access (strobes are zero for loads)
//     store_data  in  32  right-justified store data
//     rdata       in  32  word read from memory
//     wstrb       out 4   byte strobes
//     wdata       out 32  lane-replicated store data
//     load_result out 32  selected lane, sign/zero extended
//   Halfword lanes use addr_lo[1] only and word accesses always use lane 0,
//   so misaligned requests fall back to the containing aligned unit.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic        we,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_result
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_shift = rdata >> {addr_lo, 3'b000};
        half_shift = rdata >> {addr_lo[1], 4'b0000};
        byte_lane  = byte_shift[7:0];
        half_lane  = half_shift[15:0];

        wstrb       = 4'b1111;
        wdata       = store_data;
        load_result = rdata;
        case (width)
            MEM_W_B, MEM_W_BU: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
                load_result = (width == MEM_W_B) ? {{24{byte_lane[7]}}, byte_lane}
                                                 : {24'h0, byte_lane};
            end
            MEM_W_H, MEM_W_HU: begin
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
                load_result = (width == MEM_W_H) ? {{16{half_lane[15]}}, half_lane}
                                                 : {16'h0, half_lane};
            end
            default: begin
                wstrb       = 4'b1111;
                wdata       = store_data;
                load_result = rdata;
            end
        endcase

        if (!we) begin
            wstrb = 4'b0000;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage data-memory responder. Takes the load/store held in EX/MEM,
//   runs it as a single outstanding req/ack bus transaction and stalls the
//   pipeline until it completes (or times out).
//   Parameter TIMEOUT: REQ cycles to wait for bus_ack; 0 waits forever.
//   Optional feature macro: MISALIGN_CHECK_EN (reject misaligned H/W accesses).
//   Ports:
//     clk, rst (sync, active-low)
//     mem_data_mem_re/we/data_width/addr/in : request from EX/MEM
//     mem_stall       : hold IF..EX/MEM while busy
//     mem_load_data   : extended load result (valid with mem_load_valid)
//     mem_load_valid  : one-cycle pulse on load completion
//     mem_bus_err     : one-cycle pulse on timeout
//     mem_misalign    : one-cycle pulse on rejected misaligned request
//     bus_req/we/addr/wstrb/wdata : memory bus request side
//     bus_ack/rdata   : memory bus response side
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_data_mem_re,
    input  logic              mem_data_mem_we,
    input  logic [2:0]        mem_data_mem_data_width,
    input  logic [ADDR_W-1:0] mem_data_mem_addr,
    input  logic [DATA_W-1:0] mem_data_mem_in,
    output logic              mem_stall,
    output logic [31:0]       mem_load_data,
    output logic              mem_load_valid,
    output logic              mem_bus_err,
    output logic              mem_misalign,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    mau_state_t        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              we_p0;
    logic [2:0]        width_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] data_p0;
    logic [31:0]       load_ext;
    logic              req_now;
    logic              misalign_now;

    assign req_now = mem_data_mem_re | mem_data_mem_we;

`ifdef MISALIGN_CHECK_EN
    logic misalign_q;
    assign misalign_now = is_misaligned(mem_data_mem_data_width, mem_data_mem_addr[1:0]);
    assign mem_misalign = misalign_q;
`else
    assign misalign_now = 1'b0;
    assign mem_misalign = 1'b0;
`endif

    // Stall asserts in the detect cycle itself so EX/MEM holds the request.
    assign mem_stall = (state == MAU_REQ) || ((state == MAU_IDLE) && req_now);

    // The bus is driven only from captured request fields.
    assign bus_we   = we_p0;
    assign bus_addr = {addr_p0[ADDR_W-1:2], 2'b00};

    mem_lane_align u_align (
        .width       (width_p0),
        .addr_lo     (addr_p0[1:0]),
        .we          (we_p0),
        .store_data  (data_p0),
        .rdata       (bus_rdata),
        .wstrb       (bus_wstrb),
        .wdata       (bus_wdata),
        .load_result (load_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= MAU_IDLE;
            wait_cnt       <= '0;
            we_p0          <= 1'b0;
            width_p0       <= 3'b000;
            addr_p0        <= '0;
            data_p0        <= '0;
            bus_req        <= 1'b0;
            mem_load_data  <= 32'h0;
            mem_load_valid <= 1'b0;
            mem_bus_err    <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            misalign_q     <= 1'b0;
`endif
        end else begin
            mem_load_valid <= 1'b0;
            mem_bus_err    <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            misalign_q     <= 1'b0;
`endif
            case (state)
                // Request capture boundary
                MAU_IDLE: begin
                    if (req_now) begin
                        we_p0    <= mem_data_mem_we;
                        width_p0 <= mem_data_mem_data_width;
                        addr_p0  <= mem_data_mem_addr;
                        data_p0  <= mem_data_mem_in;
                        wait_cnt <= '0;
                        if (misalign_now) begin
                            state         <= MAU_RESP;
                            mem_load_data <= 32'h0;
`ifdef MISALIGN_CHECK_EN
                            misalign_q    <= 1'b1;
`endif
                        end else begin
                            state   <= MAU_REQ;
                            bus_req <= 1'b1;
                        end
                    end
                end
                // Bus wait boundary
                MAU_REQ: begin
                    if (bus_ack) begin
                        state          <= MAU_RESP;
                        bus_req        <= 1'b0;
                        mem_load_data  <= we_p0 ? 32'h0 : load_ext;
                        mem_load_valid <= ~we_p0;
                    end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                        state         <= MAU_RESP;
                        bus_req       <= 1'b0;
                        mem_load_data <= 32'h0;
                        mem_bus_err   <= 1'b1;
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                    end
                end
                // Response boundary: inputs still hold the finished request, so ignore them.
                MAU_RESP: begin
                    state <= MAU_IDLE;
                end
                default: begin
                    state   <= MAU_IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Self-checking bench for mem_access_unit (TIMEOUT=4). Directed scenarios
//   followed by randomized accesses, each scored against a byte-level model.
//   Honours MISALIGN_CHECK_EN when the build defines it.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_data_mem_re;
    logic        mem_data_mem_we;
    logic [2:0]  mem_data_mem_data_width;
    logic [31:0] mem_data_mem_addr;
    logic [31:0] mem_data_mem_in;
    logic        mem_stall;
    logic [31:0] mem_load_data;
    logic        mem_load_valid;
    logic        mem_bus_err;
    logic        mem_misalign;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .mem_data_mem_re         (mem_data_mem_re),
        .mem_data_mem_we         (mem_data_mem_we),
        .mem_data_mem_data_width (mem_data_mem_data_width),
        .mem_data_mem_addr       (mem_data_mem_addr),
        .mem_data_mem_in         (mem_data_mem_in),
        .mem_stall               (mem_stall),
        .mem_load_data           (mem_load_data),
        .mem_load_valid          (mem_load_valid),
        .mem_bus_err             (mem_bus_err),
        .mem_misalign            (mem_misalign),
        .bus_req                 (bus_req),
        .bus_we                  (bus_we),
        .bus_addr                (bus_addr),
        .bus_wstrb               (bus_wstrb),
        .bus_wdata               (bus_wdata),
        .bus_ack                 (bus_ack),
        .bus_rdata               (bus_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int lane_size(input logic [2:0] w);
        if (w == 3'b000 || w == 3'b100) return 1;
        if (w == 3'b001 || w == 3'b101) return 2;
        return 4;
    endfunction

    // Offset rounded down to the access size (natural containing unit).
    function automatic int lane_off(input logic [2:0] w, input logic [31:0] a);
        int sz = lane_size(w);
        return (int'(a[1:0]) / sz) * sz;
    endfunction

    function automatic bit model_misalign(input logic [2:0] w, input logic [31:0] a);
`ifdef MISALIGN_CHECK_EN
        return (int'(a[1:0]) % lane_size(w)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] w, input logic [31:0] a,
                                               input logic [31:0] rd);
        int    sz   = lane_size(w);
        int    off  = lane_off(w, a);
        longint span = longint'(1) << (8 * sz);
        longint val  = (longint'(rd) >> (8 * off)) % span;
        if ((w == 3'b000 || w == 3'b001) && val >= span / 2) val = val - span;
        return val[31:0];
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] w, input logic [31:0] a, input bit st);
        logic [3:0] s = 4'b0000;
        int sz  = lane_size(w);
        int off = lane_off(w, a);
        if (st) for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + sz);
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] w, input logic [31:0] d);
        logic [31:0] r;
        int sz = lane_size(w);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    // ---------------- one access, start to finish ----------------
    // Entered 1 time unit after a rising edge with the FSM idle.
    // a_delay = REQ cycles before ack; negative means never ack.
    task automatic run_access(input string nm, input bit a_we, input bit a_re,
                              input logic [2:0] a_w, input logic [31:0] a_addr,
                              input logic [31:0] a_data, input logic [31:0] a_rdata,
                              input int a_delay);
        int n_stall = 0;
        int n_req   = 0;
        int cyc     = 0;
        bit done    = 0;
        bit s_v = 0, s_e = 0, s_m = 0;
        logic [31:0] ld = '0, g_addr = '0, g_wdata = '0;
        logic [3:0]  g_strb = '0;
        logic        g_we = 1'b0;
        bit mis, tmo, st;
        int e_req, e_stall;
        logic [31:0] e_ld;

        st  = a_we;
        mis = model_misalign(a_w, a_addr);
        tmo = !mis && (a_delay < 0 || a_delay >= TMO);
        if (mis) begin
            e_req = 0; e_stall = 1; e_ld = 32'h0;
        end else if (tmo) begin
            e_req = TMO; e_stall = TMO + 1; e_ld = 32'h0;
        end else begin
            e_req = a_delay + 1; e_stall = a_delay + 2; e_ld = model_load(a_w, a_addr, a_rdata);
        end

        mem_data_mem_we         = a_we;
        mem_data_mem_re         = a_re;
        mem_data_mem_data_width = a_w;
        mem_data_mem_addr       = a_addr;
        mem_data_mem_in         = a_data;
        bus_rdata               = a_rdata;

        while (!done && cyc < 40) begin
            if (bus_req) bus_ack = (n_req == a_delay);
            else         bus_ack = 1'($urandom_range(0, 1));   // must be ignored
            @(negedge clk);
            if (mem_stall) n_stall++;
            if (bus_req) begin
                if (n_req == 0) begin
                    g_addr = bus_addr; g_we = bus_we; g_strb = bus_wstrb; g_wdata = bus_wdata;
                end
                n_req++;
            end
            if (mem_load_valid) begin s_v = 1; ld = mem_load_data; end
            if (mem_bus_err)    begin s_e = 1; ld = mem_load_data; end
            if (mem_misalign)   begin s_m = 1; ld = mem_load_data; end
            if (cyc > 0 && !mem_stall) done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        mem_data_mem_re = 1'b0;
        mem_data_mem_we = 1'b0;
        bus_ack         = 1'b0;

        check_val({nm, "_done"},  32'(done), 32'd1);
        check_val({nm, "_stall"}, 32'(n_stall), 32'(e_stall));
        check_val({nm, "_req"},   32'(n_req), 32'(e_req));
        check_val({nm, "_valid"}, 32'(s_v), 32'(!st && !mis && !tmo));
        check_val({nm, "_err"},   32'(s_e), 32'(tmo));
        check_val({nm, "_misal"}, 32'(s_m), 32'(mis));
        if (!st || mis || tmo) check_val({nm, "_ldata"}, ld, e_ld);
        if (e_req > 0) begin
            check_val({nm, "_addr"}, g_addr, a_addr & 32'hFFFF_FFFC);
            check_val({nm, "_we"},   32'(g_we), 32'(st));
            check_val({nm, "_strb"}, 32'(g_strb), 32'(model_strb(a_w, a_addr, st)));
            if (st) check_val({nm, "_wdata"}, g_wdata, model_wdata(a_w, a_data));
        end

        // Request is gone: the unit must sit idle without re-issuing.
        @(negedge clk);
        check_val({nm, "_idle_stall"}, 32'(mem_stall), 32'd0);
        check_val({nm, "_idle_req"},   32'(bus_req), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [2:0] store_codes [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
        int kind;
        bit r_we, r_re;
        logic [2:0] r_w;

        rst = 1'b0;
        mem_data_mem_re = 1'b0;
        mem_data_mem_we = 1'b0;
        mem_data_mem_data_width = 3'b000;
        mem_data_mem_addr = 32'h0;
        mem_data_mem_in = 32'h0;
        bus_ack = 1'b0;
        bus_rdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_stall", 32'(mem_stall), 32'd0);
        check_val("rst_ldata", mem_load_data, 32'h0);
        check_val("rst_valid", 32'(mem_load_valid), 32'd0);
        check_val("rst_err",   32'(mem_bus_err), 32'd0);
        check_val("rst_misal", 32'(mem_misalign), 32'd0);
        check_val("rst_req",   32'(bus_req), 32'd0);
        check_val("rst_we",    32'(bus_we), 32'd0);
        check_val("rst_addr",  bus_addr, 32'h0);
        check_val("rst_strb",  32'(bus_wstrb), 32'd0);
        check_val("rst_wdata", bus_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        run_access("sw",   1, 0, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0);
        run_access("sb",   1, 0, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0, 0);
        run_access("lb",   0, 1, 3'b000, 32'h0000_0101, 32'h0, 32'h1234_80FF, 3);
        run_access("lbu",  0, 1, 3'b100, 32'h0000_0101, 32'h0, 32'h1234_80FF, 3);
        run_access("lh3",  0, 1, 3'b001, 32'h0000_0003, 32'h0, 32'h1234_80FF, 0);
        run_access("sh",   1, 0, 3'b001, 32'h0000_0012, 32'h0000_BEEF, 32'h0, 1);
        run_access("lhu",  0, 1, 3'b101, 32'h0000_0002, 32'h0, 32'hF00D_0000, 2);
        run_access("both", 1, 1, 3'b010, 32'h0000_0040, 32'h0102_0304, 32'h0, 0);
        run_access("tmo",  0, 1, 3'b010, 32'h0000_0080, 32'h0, 32'hFFFF_FFFF, -1);

        // Reset while waiting in REQ.
        mem_data_mem_re = 1'b1;
        mem_data_mem_data_width = 3'b010;
        mem_data_mem_addr = 32'h0000_0044;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rmid_req_up", 32'(bus_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_data_mem_re = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rmid_req",   32'(bus_req), 32'd0);
        check_val("rmid_stall", 32'(mem_stall), 32'd0);
        check_val("rmid_valid", 32'(mem_load_valid), 32'd0);
        check_val("rmid_err",   32'(mem_bus_err), 32'd0);
        check_val("rmid_misal", 32'(mem_misalign), 32'd0);
        check_val("rmid_we",    32'(bus_we), 32'd0);
        check_val("rmid_addr",  bus_addr, 32'h0);
        check_val("rmid_strb",  32'(bus_wstrb), 32'd0);
        check_val("rmid_wdata", bus_wdata, 32'h0);
        check_val("rmid_ldata", mem_load_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_val("rmid_valid2", 32'(mem_load_valid), 32'd0);
        check_val("rmid_err2",   32'(mem_bus_err), 32'd0);
        @(posedge clk); #1;
        run_access("lw_after_rst", 0, 1, 3'b010, 32'h0000_0048, 32'h0, 32'hCAFE_F00D, 1);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            r_we = (kind != 0);
            r_re = (kind != 1);
            if (r_we) r_w = store_codes[$urandom_range(0, 5)];
            else      r_w = 3'($urandom_range(0, 7));
            run_access("rnd", r_we, r_re, r_w, $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 6)) - 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
